// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: MD opcode encoding, sequencer states and
// default latencies. The D/E decoder and md_sched both import this package.
package md_pkg;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTHI  = 4'd5,
      MD_MTLO  = 4'd6,
      MD_MFHI  = 4'd7,
      MD_MFLO  = 4'd8,
      MD_MADD  = 4'd9,
      MD_MADDU = 4'd10,
      MD_MSUB  = 4'd11,
      MD_MSUBU = 4'd12
   } md_op_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

   localparam int MD_MUL_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF = 10;

endpackage

// File: rtl/md_sched.sv
// MIPS HI/LO multiply/divide sequencer: fixed MUL_CYCLES/DIV_CYCLES busy window, stalls D while busy.
// `MD_MADD_EN enables MADD/MADDU/MSUB/MSUBU; otherwise those opcodes behave as MD_NONE.
module md_sched
   import md_pkg::*;
#(
   parameter int MUL_CYCLES = MD_MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = MD_DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  op_E,
   input  logic [31:0] rs_E,
   input  logic [31:0] rt_E,
   input  logic        md_D,
   output logic        busy,
   output logic        stall_D,
   output logic [31:0] md_out_E,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_e   state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] hi_nx_q, hi_nx_d;
   logic [31:0] lo_nx_q, lo_nx_d;

   md_op_e      op;
   logic        is_mul;
   logic        is_div;
   logic        is_madd;
   logic        start_op_E;

   logic [63:0] a_sx, b_sx, a_zx, b_zx;
   logic [63:0] prod_s, prod_u;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, q_mag, r_mag;
   logic [31:0] q_s, r_s, q_u, r_u;
   logic [31:0] res_hi, res_lo;

   // ---------------- opcode decode ----------------
   always_comb begin
      op      = md_op_e'(op_E);
      is_mul  = (op == MD_MULT) || (op == MD_MULTU);
      is_div  = (op == MD_DIV)  || (op == MD_DIVU);
`ifdef MD_MADD_EN
      is_madd = (op == MD_MADD) || (op == MD_MADDU) ||
                (op == MD_MSUB) || (op == MD_MSUBU);
`else
      is_madd = 1'b0;
`endif
      start_op_E = is_mul || is_div || is_madd;
   end

   // ---------------- arithmetic ----------------
   always_comb begin
      a_sx   = {{32{rs_E[31]}}, rs_E};
      b_sx   = {{32{rt_E[31]}}, rt_E};
      a_zx   = {32'd0, rs_E};
      b_zx   = {32'd0, rt_E};
      prod_s = a_sx * b_sx;
      prod_u = a_zx * b_zx;

      // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
      a_neg  = rs_E[31];
      b_neg  = rt_E[31];
      a_mag  = a_neg ? (32'd0 - rs_E) : rs_E;
      b_mag  = b_neg ? (32'd0 - rt_E) : rt_E;
      q_mag  = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
      r_mag  = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
      q_s    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      r_s    = a_neg ? (32'd0 - r_mag) : r_mag;
      q_u    = (rt_E == 32'd0) ? 32'd0 : (rs_E / rt_E);
      r_u    = (rt_E == 32'd0) ? 32'd0 : (rs_E % rt_E);
   end

   always_comb begin
      res_hi = hi_q;
      res_lo = lo_q;
      case (op)
         MD_MULT:  {res_hi, res_lo} = prod_s;
         MD_MULTU: {res_hi, res_lo} = prod_u;
         // Divide by zero keeps HI/LO: the commit just rewrites the current values.
         MD_DIV: begin
            if (rt_E != 32'd0) begin
               res_hi = r_s;
               res_lo = q_s;
            end
         end
         MD_DIVU: begin
            if (rt_E != 32'd0) begin
               res_hi = r_u;
               res_lo = q_u;
            end
         end
`ifdef MD_MADD_EN
         MD_MADD:  {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
         MD_MADDU: {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
         MD_MSUB:  {res_hi, res_lo} = {hi_q, lo_q} - prod_s;
         MD_MSUBU: {res_hi, res_lo} = {hi_q, lo_q} - prod_u;
`endif
         default: begin
            res_hi = hi_q;
            res_lo = lo_q;
         end
      endcase
   end

   // ---------------- sequencer ----------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      hi_nx_d = hi_nx_q;
      lo_nx_d = lo_nx_q;

      case (state_q)
         MD_IDLE: begin
            if (start_op_E) begin
               hi_nx_d = res_hi;
               lo_nx_d = res_lo;
               cnt_d   = is_div ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
               state_d = MD_RUN;
            end else if (op == MD_MTHI) begin
               hi_d = rs_E;
            end else if (op == MD_MTLO) begin
               lo_d = rs_E;
            end
         end
         MD_RUN: begin
            // Anything issued to E here is dropped; stall_D keeps it from happening.
            if (cnt_q <= 4'd1) begin
               hi_d    = hi_nx_q;
               lo_d    = lo_nx_q;
               cnt_d   = 4'd0;
               state_d = MD_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = MD_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MD_IDLE;
         cnt_q   <= 4'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         hi_nx_q <= 32'd0;
         lo_nx_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         hi_nx_q <= hi_nx_d;
         lo_nx_q <= lo_nx_d;
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      busy    = (state_q == MD_RUN);
      stall_D = md_D && (busy || start_op_E);
      hi      = hi_q;
      lo      = lo_q;
      case (op)
         MD_MFHI: md_out_E = hi_q;
         MD_MFLO: md_out_E = lo_q;
         default: md_out_E = 32'd0;
      endcase
   end

endmodule

// File: doc/md_sched.md
# md_sched

Multiply/divide sequencer for the 5-stage MIPS pipeline. Accepts MD instructions issued from the E stage, owns the HI/LO registers, and models the fixed multi-cycle latency of MULT/DIV with a busy counter. Drives `md_out_E`, which the E/M pipeline register captures for MFHI/MFLO. Raises the D-stage stall request that freezes the fetch/decode registers and bubbles the D/E register while an MD instruction cannot proceed.

## Interface
Parameters:
- `MUL_CYCLES`, default 5: busy cycles for MULT/MULTU (and MADD family).
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `op_E`  in  4  MD opcode of the instruction in E (`MD_NONE` when not an MD instruction)
- `rs_E`  in  32  forwarded rs operand
- `rt_E`  in  32  forwarded rt operand
- `md_D`  in  1  instruction in D is any MD opcode
- `busy`  out  1  multi-cycle operation in progress
- `stall_D`  out  1  stall request for D stage
- `md_out_E`  out  32  HI for `MD_MFHI`, LO for `MD_MFLO`, else 0
- `hi`, `lo`  out  32  architectural HI/LO

## Operation
- States: `IDLE`, `RUN`. Down-counter `cnt` (4 bits).
- `IDLE` + start op (`MD_MULT/MULTU/DIV/DIVU`): latch operands, compute result into `hi_nx/lo_nx`, load `cnt` with the op's latency, go to `RUN`.
- `RUN`: decrement `cnt` each cycle; at `cnt==1` commit `hi_nx/lo_nx` to HI/LO and return to `IDLE`.
- `MD_MTHI`/`MD_MTLO` in `IDLE`: HI/LO <= `rs_E` next edge, no busy.
- MULT: signed 64-bit product, HI=upper, LO=lower. MULTU unsigned.
- DIV: LO=quotient truncated toward zero, HI=remainder with dividend's sign. DIVU unsigned. 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: operation runs full latency, HI/LO unchanged at commit.
- `stall_D = md_D & (busy | start_op_E)`.
- Start ops, MTHI/MTLO, or MFHI/MFLO arriving while `RUN`: ignored (stall guarantees never occurs); no state change.
- `md_out_E` is combinational from current HI/LO.

## Timing
- Reset: state `IDLE`, `cnt`=0, HI=LO=0, `busy`=0, `stall_D`=0 (unless `md_D` and start op present after reset release).
- Start op in E at cycle t: `busy`=1 cycles t+1..t+N; HI/LO new value visible from t+N+1; `busy`=0 at t+N+1.
- A D-stage MD instruction behind the start op is stalled cycles t..t+N, enters E at t+N+1.
- Back-to-back MULT then MFLO: MFLO reads committed value, never stale.
- Reset during `RUN`: abort, no commit, HI=LO=0 next cycle.
- MTHI in cycle t: HI updated at edge end of t; MFHI in t+1 returns it.

## Configuration
- `MD_MADD_EN`: defined -> opcodes `MD_MADD/MADDU/MSUB/MSUBU` accepted, latency `MUL_CYCLES`, result {HI,LO} +/- product (signed/unsigned), 64-bit wrap. Undefined -> these opcodes treated as `MD_NONE` (no busy, no stall, HI/LO unchanged).

## Structure
- Shared package `md_pkg`: 4-bit opcode enum (`MD_NONE`, `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`, `MD_MFHI`, `MD_MFLO`, MADD family), state enum, default latency constants. Decoder in D/E uses the same package.
- No sub-module; arithmetic and counter inline.

## Test plan
- MULT rs=0xFFFFFFFE (-2), rt=3 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIVU rs=100, rt=7 with MFLO in D -> stall_D 11 cycles, then md_out_E=14; MFHI -> 2.
- DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV by 0 after MTHI 0x55 -> HI stays 0x55.
- Reset asserted at cycle 3 of MULT 6*7 -> HI=LO=0, busy=0, no later commit.
- MTLO 0x1234 then immediate MFLO -> md_out_E=0x1234, no stall.
- With `MD_MADD_EN`: HI:LO=0:0xFFFFFFFF, MADDU 1*1 -> HI=1, LO=0; without it busy stays 0.
